// File: rtl/matrix_walk_controller_if.sv
// Handshake/config bundle between the control FSM (master) and the matrix walk sequencer (slave).
// The i_Col_Major member exists only when COL_MAJOR_WALK_EN is defined.
interface matrix_walk_controller_if #(
  parameter int IDX_W  = 8,
  parameter int TYPE_W = 3,
  parameter int CFG_W  = 32,
  parameter int CNT_W  = 16
);
  logic [CFG_W-1:0]  i_Config;
  logic              i_Start;
  logic [TYPE_W-1:0] i_Type;
  logic              i_Abort;
  logic              i_Ready;
`ifdef COL_MAJOR_WALK_EN
  logic              i_Col_Major;
`endif
  logic [IDX_W-1:0]  o_Row_Index;
  logic [IDX_W-1:0]  o_Column_Index;
  logic [TYPE_W-1:0] o_Type;
  logic              o_Valid;
  logic              o_Last;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Error;
  logic [CNT_W-1:0]  o_Beat_Count;

  modport master (
`ifdef COL_MAJOR_WALK_EN
    output i_Col_Major,
`endif
    output i_Config, i_Start, i_Type, i_Abort, i_Ready,
    input  o_Row_Index, o_Column_Index, o_Type, o_Valid, o_Last,
    input  o_Busy, o_Done, o_Error, o_Beat_Count
  );

  modport slave (
`ifdef COL_MAJOR_WALK_EN
    input  i_Col_Major,
`endif
    input  i_Config, i_Start, i_Type, i_Abort, i_Ready,
    output o_Row_Index, o_Column_Index, o_Type, o_Valid, o_Last,
    output o_Busy, o_Done, o_Error, o_Beat_Count
  );
endinterface

// File: rtl/matrix_walk_controller.sv
// Walks every (row, column) of the selected operand matrix, one index beat per valid/ready transfer.
// Optional COL_MAJOR_WALK_EN adds a column-major walk order selected at start.
module matrix_walk_controller #(
  parameter int IDX_W  = 8,
  parameter int TYPE_W = 3,
  parameter int CFG_W  = 32,
  parameter int CNT_W  = 16
) (
  input logic                     i_Clock,
  input logic                     i_Reset_n,
  matrix_walk_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [TYPE_W-1:0] TYPE_A  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_B  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TYPE_C  = TYPE_W'(4);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              walk_col_major;

  logic [IDX_W-1:0]  dim_l, dim_g, dim_m;
  logic [IDX_W-1:0]  sel_rows, sel_cols;
  logic              type_legal;
  logic              row_end, col_end, last, transfer;
  logic              unused_cfg;

  assign dim_l      = bus.i_Config[IDX_W-1:0];
  assign dim_g      = bus.i_Config[2*IDX_W-1:IDX_W];
  assign dim_m      = bus.i_Config[3*IDX_W-1:2*IDX_W];
  assign unused_cfg = ^bus.i_Config[CFG_W-1:3*IDX_W];

`ifdef COL_MAJOR_WALK_EN
  logic col_major_q, col_major_d;
  assign walk_col_major = col_major_q;
`else
  assign walk_col_major = 1'b0;
`endif

  // A is L x G, B is G x M, C is L x M
  always_comb begin
    type_legal = 1'b1;
    sel_rows   = dim_l;
    sel_cols   = dim_g;
    case (bus.i_Type)
      TYPE_A: begin
        sel_rows = dim_l;
        sel_cols = dim_g;
      end
      TYPE_B: begin
        sel_rows = dim_g;
        sel_cols = dim_m;
      end
      TYPE_C: begin
        sel_rows = dim_l;
        sel_cols = dim_m;
      end
      default: type_legal = 1'b0;
    endcase
  end

  assign row_end  = (row_q == rows_q - IDX_ONE);
  assign col_end  = (col_q == cols_q - IDX_ONE);
  assign last     = (state_q == S_RUN) && row_end && col_end;
  assign transfer = (state_q == S_RUN) && bus.i_Ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    type_d  = type_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef COL_MAJOR_WALK_EN
    col_major_d = col_major_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_Start && !bus.i_Abort) begin
          cnt_d = '0;
          if (type_legal) begin
            type_d = bus.i_Type;
            rows_d = sel_rows;
            cols_d = sel_cols;
            err_d  = 1'b0;
            row_d  = '0;
            col_d  = '0;
`ifdef COL_MAJOR_WALK_EN
            col_major_d = bus.i_Col_Major;
`endif
            // An empty matrix completes without emitting any beat
            state_d = (sel_rows != '0 && sel_cols != '0) ? S_RUN : S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (transfer) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last) begin
            state_d = S_DONE;
          end else if (walk_col_major) begin
            if (row_end) begin
              row_d = '0;
              col_d = col_q + IDX_ONE;
            end else begin
              row_d = row_q + IDX_ONE;
            end
          end else begin
            if (col_end) begin
              col_d = '0;
              row_d = row_q + IDX_ONE;
            end else begin
              col_d = col_q + IDX_ONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over start and transfer, but a beat accepted this cycle is still counted
    if (bus.i_Abort) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      type_q  <= type_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef COL_MAJOR_WALK_EN
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      col_major_q <= 1'b0;
    end else begin
      col_major_q <= col_major_d;
    end
  end
`endif

  assign bus.o_Row_Index    = row_q;
  assign bus.o_Column_Index = col_q;
  assign bus.o_Type         = type_q;
  assign bus.o_Valid        = (state_q == S_RUN);
  assign bus.o_Last         = last;
  assign bus.o_Busy         = (state_q != S_IDLE);
  assign bus.o_Done         = (state_q == S_DONE);
  assign bus.o_Error        = err_q;
  assign bus.o_Beat_Count   = cnt_q;

endmodule

// File: tb/tb_matrix_walk_controller.sv
// Table-driven bench for matrix_walk_controller plus hand sequences for abort and reset.
// Define COL_MAJOR_WALK_EN to also exercise the column-major walk.
module tb_matrix_walk_controller;

  logic clk;
  logic rst_n;

  matrix_walk_controller_if bus ();

  matrix_walk_controller dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cfg;
    logic [2:0]  typ;
    int          ready_mode;   // 0: always 1, 1: 1/0 toggle, 2: 1,1,0 repeat
    bit          cm;
    bit          mid_start;
    int          exp_rows;
    int          exp_cols;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] cfg, input logic [2:0] typ, input int rm,
                              input bit cm, input bit ms, input int er, input int ec, input bit ee);
    vec_t v;
    v.cfg = cfg; v.typ = typ; v.ready_mode = rm; v.cm = cm; v.mid_start = ms;
    v.exp_rows = er; v.exp_cols = ec; v.exp_err = ee;
    return v;
  endfunction

  function automatic bit ready_at(input int mode, input int phase);
    case (mode)
      1:       return (phase % 2) == 0;
      2:       return (phase % 3) != 2;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes it is entered just after a rising edge with the DUT idle
  task automatic run_vec(input vec_t v, input int idx);
    int er = 0, ec = 0, beats = 0, cyc = 0, phase = 0, last_xfer = -10, done_cyc = -1;
    int exp_beats = v.exp_rows * v.exp_cols;
    bit done_seen = 0, valid_seen = 0, rdy;
    bus.i_Config = v.cfg;
    bus.i_Type   = v.typ;
    bus.i_Start  = 1'b1;
    bus.i_Ready  = 1'b0;
`ifdef COL_MAJOR_WALK_EN
    bus.i_Col_Major = v.cm;
`endif
    tick();
    bus.i_Start  = 1'b0;
    bus.i_Config = 32'h0001_0101;
    bus.i_Type   = 3'b000;
    while (!done_seen && cyc < 1000) begin
      if (bus.o_Done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end else begin
        if (bus.o_Valid) begin
          valid_seen = 1;
          chk($sformatf("v%0d row", idx), 32'(bus.o_Row_Index), 32'(er));
          chk($sformatf("v%0d col", idx), 32'(bus.o_Column_Index), 32'(ec));
          chk($sformatf("v%0d last", idx), 32'(bus.o_Last),
              32'((er == v.exp_rows - 1) && (ec == v.exp_cols - 1)));
          chk($sformatf("v%0d type", idx), 32'(bus.o_Type), 32'(v.typ));
          rdy = ready_at(v.ready_mode, phase);
          phase++;
          bus.i_Ready = rdy;
          if (v.mid_start && beats >= 3 && beats < 6) begin
            bus.i_Start  = 1'b1;
            bus.i_Config = 32'h0002_0202;
          end else begin
            bus.i_Start  = 1'b0;
          end
          if (rdy) begin
            beats++;
            last_xfer = cyc;
            if (v.cm) begin
              if (er == v.exp_rows - 1) begin er = 0; ec++; end
              else er++;
            end else begin
              if (ec == v.exp_cols - 1) begin ec = 0; er++; end
              else ec++;
            end
          end
        end
        tick();
        cyc++;
      end
    end
    bus.i_Start = 1'b0;
    bus.i_Ready = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d beats", idx), 32'(beats), 32'(exp_beats));
    chk($sformatf("v%0d beat_count", idx), 32'(bus.o_Beat_Count), 32'(exp_beats));
    chk($sformatf("v%0d error", idx), 32'(bus.o_Error), 32'(v.exp_err));
    chk($sformatf("v%0d done_valid", idx), 32'(bus.o_Valid), 32'd0);
    chk($sformatf("v%0d done_busy", idx), 32'(bus.o_Busy), 32'd1);
    if (exp_beats > 0) begin
      chk($sformatf("v%0d done_latency", idx), 32'(done_cyc - last_xfer), 32'd1);
      chk($sformatf("v%0d held_row", idx), 32'(bus.o_Row_Index), 32'(v.exp_rows - 1));
      chk($sformatf("v%0d held_col", idx), 32'(bus.o_Column_Index), 32'(v.exp_cols - 1));
    end else begin
      chk($sformatf("v%0d valid_never", idx), 32'(valid_seen), 32'd0);
      chk($sformatf("v%0d done_latency", idx), 32'(done_cyc), 32'd0);
    end
    tick();
    chk($sformatf("v%0d done_pulse_end", idx), 32'(bus.o_Done), 32'd0);
    chk($sformatf("v%0d idle_busy", idx), 32'(bus.o_Busy), 32'd0);
    chk($sformatf("v%0d sticky_error", idx), 32'(bus.o_Error), 32'(v.exp_err));
    chk($sformatf("v%0d count_hold", idx), 32'(bus.o_Beat_Count), 32'(exp_beats));
    $display("vec %0d: cfg=%h type=%b ready_mode=%0d beats=%0d done=%0d err=%0d",
             idx, v.cfg, v.typ, v.ready_mode, beats, done_seen, bus.o_Error);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"}, 32'(bus.o_Valid), 32'd0);
    chk({tag, " last"},  32'(bus.o_Last), 32'd0);
    chk({tag, " busy"},  32'(bus.o_Busy), 32'd0);
    chk({tag, " done"},  32'(bus.o_Done), 32'd0);
    chk({tag, " error"}, 32'(bus.o_Error), 32'd0);
    chk({tag, " row"},   32'(bus.o_Row_Index), 32'd0);
    chk({tag, " col"},   32'(bus.o_Column_Index), 32'd0);
    chk({tag, " type"},  32'(bus.o_Type), 32'd0);
    chk({tag, " count"}, 32'(bus.o_Beat_Count), 32'd0);
  endtask

  task automatic start_walk(input logic [31:0] cfg, input logic [2:0] typ);
    bus.i_Config = cfg;
    bus.i_Type   = typ;
    bus.i_Start  = 1'b1;
    tick();
    bus.i_Start  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    bus.i_Config = '0;
    bus.i_Start  = 1'b0;
    bus.i_Type   = '0;
    bus.i_Abort  = 1'b0;
    bus.i_Ready  = 1'b0;
`ifdef COL_MAJOR_WALK_EN
    bus.i_Col_Major = 1'b0;
`endif

    vecs.push_back(mk(32'h0008_0808, 3'b000, 0, 0, 0, 8, 8, 0));
    vecs.push_back(mk(32'h0004_0808, 3'b010, 1, 0, 0, 8, 4, 0));
    vecs.push_back(mk(32'h0004_0808, 3'b011, 0, 0, 0, 8, 0, 1));
    vecs.push_back(mk(32'h0004_0808, 3'b100, 0, 0, 0, 8, 4, 0));
    vecs.push_back(mk(32'h0000_0808, 3'b100, 0, 0, 0, 8, 0, 0));
    vecs.push_back(mk(32'h0004_0808, 3'b100, 2, 0, 1, 8, 4, 0));
    vecs.push_back(mk(32'hFF03_0205, 3'b000, 2, 0, 0, 5, 2, 0));
    vecs.push_back(mk(32'h0000_0101, 3'b000, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(32'h0001_0101, 3'b110, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(32'h0003_0502, 3'b010, 1, 0, 0, 5, 3, 0));
`ifdef COL_MAJOR_WALK_EN
    vecs.push_back(mk(32'h0008_0808, 3'b000, 0, 1, 0, 8, 8, 0));
    vecs.push_back(mk(32'h0004_0308, 3'b100, 1, 1, 0, 8, 4, 0));
`endif

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abort after 10 accepted beats
    start_walk(32'h0008_0808, 3'b000);
    bus.i_Ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    bus.i_Ready = 1'b0;
    bus.i_Abort = 1'b1;
    tick();
    bus.i_Abort = 1'b0;
    chk("abort valid", 32'(bus.o_Valid), 32'd0);
    chk("abort last",  32'(bus.o_Last), 32'd0);
    chk("abort busy",  32'(bus.o_Busy), 32'd0);
    chk("abort done",  32'(bus.o_Done), 32'd0);
    chk("abort count", 32'(bus.o_Beat_Count), 32'd10);
    chk("abort error", 32'(bus.o_Error), 32'd0);
    tick();
    chk("abort no_done", 32'(bus.o_Done), 32'd0);
    chk("abort count_hold", 32'(bus.o_Beat_Count), 32'd10);
    $display("abort after 10 beats: count=%0d busy=%0d", bus.o_Beat_Count, bus.o_Busy);

    // Beat presented in the abort cycle with ready high still counts
    start_walk(32'h0008_0808, 3'b000);
    bus.i_Ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.i_Abort = 1'b1;
    tick();
    bus.i_Abort = 1'b0;
    bus.i_Ready = 1'b0;
    chk("abort_xfer count", 32'(bus.o_Beat_Count), 32'd4);
    chk("abort_xfer busy",  32'(bus.o_Busy), 32'd0);
    $display("abort with ready: count=%0d", bus.o_Beat_Count);

    // Abort beats a simultaneous start in IDLE
    bus.i_Abort = 1'b1;
    start_walk(32'h0008_0808, 3'b000);
    bus.i_Abort = 1'b0;
    chk("abort_start busy",  32'(bus.o_Busy), 32'd0);
    chk("abort_start count", 32'(bus.o_Beat_Count), 32'd4);
    $display("abort with start in idle: busy=%0d", bus.o_Busy);

    // Error then abort: error survives the abort
    start_walk(32'h0008_0808, 3'b111);
    bus.i_Abort = 1'b1;
    tick();
    bus.i_Abort = 1'b0;
    chk("err_abort error", 32'(bus.o_Error), 32'd1);
    chk("err_abort done",  32'(bus.o_Done), 32'd0);
    $display("illegal start then abort: error=%0d", bus.o_Error);

    // Asynchronous reset in the middle of a walk
    start_walk(32'h0008_0808, 3'b100);
    bus.i_Ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.i_Ready = 1'b0;
    tick();
    check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("reset_release");
    $display("reset mid-walk: busy=%0d count=%0d", bus.o_Busy, bus.o_Beat_Count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
